// File: rtl/bb_cg_pkg.sv
// Shared types for the clock-gate controller: state encoding and
// the width of the optional gated-cycle statistics counter.
package bb_cg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_t;

    localparam int STATS_W = 32;

endpackage

// File: rtl/bb_cg_cnt.sv
// Clearable saturating up-counter with an equality compare output.
// Ports: clk, rst_n (sync, active-low), clr, inc, cmp -> cnt, eq.
module bb_cg_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] cmp,
    output logic [CNT_W-1:0] cnt,
    output logic             eq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign eq = (cnt == cmp);

endmodule

// File: rtl/bb_clk_gate_ctrl.sv
// Clock-gate controller: idle hysteresis, quiesce handshake, timed wake.
// Ports: raw_clk, rst_n (sync, active-low), cfg_en, busy, wake_req,
//   quiesce_ack -> quiesce_req, active, bypass, wake_ack, cg_state.
// Optional BB_CG_STATS_EN adds stats_clr in, gated_cycles[31:0] out.
module bb_clk_gate_ctrl
    import bb_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       raw_clk,
    input  logic       rst_n,
    input  logic       cfg_en,
    input  logic       busy,
    input  logic       wake_req,
    input  logic       quiesce_ack,
    output logic       quiesce_req,
    output logic       active,
    output logic       bypass,
    output logic       wake_ack,
    output logic [1:0] cg_state
`ifdef BB_CG_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [STATS_W-1:0] gated_cycles
`endif
);

    localparam logic [CNT_W-1:0] IDLE_CMP = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_CMP = CNT_W'(WAKE_CYCLES - 1);

    cg_state_t        state;
    logic             abort;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             cnt_eq;
    logic [CNT_W-1:0] cnt_cmp;
    logic [CNT_W-1:0] cnt;

    // Any reason to keep (or bring back) the clock.
    assign abort = busy || wake_req || !cfg_en;

    // One counter serves both idle hysteresis and wake timing; it is
    // cleared whenever it is not counting and on reaching its target.
    assign cnt_inc = ((state == RUN) && !abort) || (state == WAKE);
    assign cnt_clr = !cnt_inc || cnt_eq;
    assign cnt_cmp = (state == WAKE) ? WAKE_CMP : IDLE_CMP;

    bb_cg_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (raw_clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cmp   (cnt_cmp),
        .cnt   (cnt),
        .eq    (cnt_eq)
    );

    always_ff @(posedge raw_clk) begin
        if (!rst_n) begin
            state       <= RUN;
            active      <= 1'b1;
            bypass      <= 1'b1;
            quiesce_req <= 1'b0;
            wake_ack    <= 1'b0;
        end else begin
            bypass   <= !cfg_en;
            wake_ack <= 1'b0;
            unique case (state)
                RUN: begin
                    if (!abort && cnt_eq) begin
                        state       <= DRAIN;
                        quiesce_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Abort outranks an acknowledge in the same cycle.
                    if (abort) begin
                        state       <= RUN;
                        quiesce_req <= 1'b0;
                    end else if (quiesce_ack) begin
                        state  <= GATED;
                        active <= 1'b0;
                    end
                end
                GATED: begin
                    if (abort) begin
                        state  <= WAKE;
                        active <= 1'b1;
                    end
                end
                WAKE: begin
                    // Inputs are ignored: a wake always runs to completion.
                    if (cnt_eq) begin
                        state       <= RUN;
                        quiesce_req <= 1'b0;
                        wake_ack    <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign cg_state = state;

`ifdef BB_CG_STATS_EN
    localparam logic [STATS_W-1:0] STATS_MAX = '1;

    always_ff @(posedge raw_clk) begin
        if (!rst_n || stats_clr) begin
            gated_cycles <= '0;
        end else if ((state == GATED) && (gated_cycles != STATS_MAX)) begin
            gated_cycles <= gated_cycles + STATS_W'(1);
        end
    end
`endif

    // cnt is observed only through the compare output.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_bb_clk_gate_ctrl.sv
// Self-checking bench for bb_clk_gate_ctrl (default parameters).
// Table of cycle-count/input/expected records plus directed corner cases.
module tb_bb_clk_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_en;
    logic       busy;
    logic       wake_req;
    logic       quiesce_ack;
    logic       quiesce_req;
    logic       active;
    logic       bypass;
    logic       wake_ack;
    logic [1:0] cg_state;
`ifdef BB_CG_STATS_EN
    logic        stats_clr;
    logic [31:0] gated_cycles;
`endif

    int total;
    int bad;

    bb_clk_gate_ctrl #(
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2),
        .CNT_W       (8)
    ) dut (
        .raw_clk     (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .busy        (busy),
        .wake_req    (wake_req),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .active      (active),
        .bypass      (bypass),
        .wake_ack    (wake_ack),
        .cg_state    (cg_state)
`ifdef BB_CG_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .gated_cycles (gated_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       rst_n;
        logic       cfg;
        logic       busy;
        logic       wr;
        logic       qa;
        logic [1:0] st;
        logic       a;
        logic       b;
        logic       q;
        logic       w;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int n, logic r, logic c, logic bz,
                                logic wr, logic qa, logic [1:0] st,
                                logic a, logic b, logic q, logic w);
        vec_t v;
        v.n = n; v.rst_n = r; v.cfg = c; v.busy = bz;
        v.wr = wr; v.qa = qa; v.st = st;
        v.a = a; v.b = b; v.q = q; v.w = w;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit found;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        cfg_en = 1'b1;
        busy = 1'b0;
        wake_req = 1'b0;
        quiesce_ack = 1'b0;
`ifdef BB_CG_STATS_EN
        stats_clr = 1'b0;
`endif

        //             n  rst cfg bz wr qa  st  a  b  q  w
        vecs.push_back(mk(2,  0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(15, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 2, 0, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 0, 1, 0, 3, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 1, 1, 0, 3, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1,  1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(10, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(15, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 1, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(14, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(3,  1, 1, 0, 0, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(1,  1, 0, 0, 0, 0, 3, 1, 1, 1, 0));
        vecs.push_back(mk(1,  1, 0, 0, 0, 0, 3, 1, 1, 1, 0));
        vecs.push_back(mk(1,  1, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(14, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 1, 2, 0, 0, 1, 0));
        vecs.push_back(mk(1,  0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1,  1, 1, 0, 0, 0, 0, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n       = vecs[i].rst_n;
            cfg_en      = vecs[i].cfg;
            busy        = vecs[i].busy;
            wake_req    = vecs[i].wr;
            quiesce_ack = vecs[i].qa;
            repeat (vecs[i].n) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d.state", i), 32'(cg_state), 32'(vecs[i].st));
            chk($sformatf("v%0d.active", i), 32'(active), 32'(vecs[i].a));
            chk($sformatf("v%0d.bypass", i), 32'(bypass), 32'(vecs[i].b));
            chk($sformatf("v%0d.qreq", i), 32'(quiesce_req), 32'(vecs[i].q));
            chk($sformatf("v%0d.wack", i), 32'(wake_ack), 32'(vecs[i].w));
        end

        // Gating disabled and idle for 100 cycles: no quiesce request.
        cfg_en = 1'b0;
        busy = 1'b0;
        wake_req = 1'b0;
        quiesce_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("cfg_off.qreq%0d", i), 32'(quiesce_req), 32'd0);
            chk($sformatf("cfg_off.st%0d", i), 32'(cg_state), 32'd0);
        end
        chk("cfg_off.bypass", 32'(bypass), 32'd1);
        quiesce_ack = 1'b0;

`ifdef BB_CG_STATS_EN
        cfg_en = 1'b1;
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("stats.cleared", gated_cycles, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (cg_state == 2'd1) found = 1'b1;
        end
        chk("stats.drain_reached", 32'(found), 32'd1);
        quiesce_ack = 1'b1;
        step();
        quiesce_ack = 1'b0;
        chk("stats.gated", 32'(cg_state), 32'd2);
        chk("stats.zero_at_entry", gated_cycles, 32'd0);
        repeat (5) step();
        chk("stats.five", gated_cycles, 32'd5);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        chk("stats.clr_wins", gated_cycles, 32'd0);
        step();
        chk("stats.resume", gated_cycles, 32'd1);
`else
        found = 1'b0;
        chk("nostats.found_idle", 32'(found), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
